// File: rtl/audio_pkg.sv
// Shared widths and FSM state encoding for the audio tone scheduler.
package audio_pkg;

    localparam int unsigned CNT_W = 17;
    localparam int unsigned DUR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV cycles after the last clear.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_tone_sched.sv
// Round-robin scheduler of two tone requesters onto one PWM channel, with timed
// tone playback and a silent gap after each tone.
module audio_tone_sched
    import audio_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned GAP_TICKS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [CNT_W-1:0] period_a,
    input  logic [DUR_W-1:0] dur_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [CNT_W-1:0] period_b,
    input  logic [DUR_W-1:0] dur_b,
    output logic             ack_b,
    input  logic             abort,
    output logic [CNT_W-1:0] pwm_period,
    output logic [CNT_W-1:0] pwm_ref,
    output logic             pwm_en,
    output logic             busy,
    output logic             done,
    output logic             grant_b
);

    state_e           state_q, state_d;
    logic             grant_b_q, grant_b_d;
    logic             last_b_q, last_b_d;
    logic [CNT_W-1:0] pwm_period_q, pwm_period_d;
    logic [CNT_W-1:0] pwm_ref_q, pwm_ref_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick, tick_clr;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        grant_b_d    = grant_b_q;
        last_b_d     = last_b_q;
        pwm_period_d = pwm_period_q;
        pwm_ref_d    = pwm_ref_q;
        dur_d        = dur_q;
        tick_cnt_d   = tick_cnt_q;
        tick_clr     = 1'b0;
        ack_a        = 1'b0;
        ack_b        = 1'b0;
        done         = 1'b0;
        pwm_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // On a tie the side not granted last time wins.
                    grant_b_d = req_b && (!req_a || !last_b_q);
                    last_b_d  = grant_b_d;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                ack_a        = !grant_b_q;
                ack_b        = grant_b_q;
                pwm_period_d = grant_b_q ? period_b : period_a;
                pwm_ref_d    = pwm_period_d >> 1;
                dur_d        = grant_b_q ? dur_b : dur_a;
                tick_cnt_d   = '0;
                tick_clr     = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (dur_d == '0) begin
                    state_d = GAP;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                pwm_en = (pwm_period_q != '0);
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (tick_cnt_q == dur_q - DUR_W'(1)) begin
                        done       = 1'b1;
                        state_d    = GAP;
                        tick_cnt_d = '0;
                        tick_clr   = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + DUR_W'(1);
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (tick_cnt_q == DUR_W'(GAP_TICKS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + DUR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_b_q    <= 1'b0;
            last_b_q     <= 1'b1;
            pwm_period_q <= '0;
            pwm_ref_q    <= '0;
            dur_q        <= '0;
            tick_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_b_q    <= grant_b_d;
            last_b_q     <= last_b_d;
            pwm_period_q <= pwm_period_d;
            pwm_ref_q    <= pwm_ref_d;
            dur_q        <= dur_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

    assign pwm_period = pwm_period_q;
    assign pwm_ref    = pwm_ref_q;
    assign busy       = (state_q != IDLE);
    assign grant_b    = grant_b_q;

endmodule

// File: tb/tb_audio_tone_sched.sv
// Directed bench for audio_tone_sched with TICK_DIV=4, GAP_TICKS=2.
module tb_audio_tone_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, abort;
    logic [16:0] period_a, period_b;
    logic [15:0] dur_a, dur_b;
    logic        ack_a, ack_b;
    logic [16:0] pwm_period, pwm_ref;
    logic        pwm_en, busy, done, grant_b;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    audio_tone_sched #(
        .TICK_DIV (4),
        .GAP_TICKS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .period_a  (period_a),
        .dur_a     (dur_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .period_b  (period_b),
        .dur_b     (dur_b),
        .ack_b     (ack_b),
        .abort     (abort),
        .pwm_period(pwm_period),
        .pwm_ref   (pwm_ref),
        .pwm_en    (pwm_en),
        .busy      (busy),
        .done      (done),
        .grant_b   (grant_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_grant(input string tag, input logic b, input int budget,
                                output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!(ack_a || ack_b) && cnt < budget);
        chk({tag, "_ack"}, {30'd0, ack_b, ack_a}, b ? 32'd2 : 32'd1);
        chk({tag, "_grant_b"}, grant_b, b);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int cnt = 0;
        while (busy && cnt < budget) begin
            step(1);
            cnt++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pwm_period"}, pwm_period, 0);
        chk({tag, "_pwm_ref"}, pwm_ref, 0);
        chk({tag, "_pwm_en"}, pwm_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_grant_b"}, grant_b, 0);
        chk({tag, "_acks"}, {ack_a, ack_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_a = 0; req_b = 0; abort = 0;
        period_a = '0; period_b = '0; dur_a = '0; dur_b = '0;
        #1;
        chk_all_zero("reset");
        step(2);
        reset = 1'b1;

        // Single A tone: period 1000, 3 ticks -> 12 PLAY cycles, 8 GAP cycles.
        req_a = 1; period_a = 17'd1000; dur_a = 16'd3;
        expect_grant("s1", 1'b0, 4, n);
        chk("s1_latency", n, 1);
        chk("s1_busy_load", busy, 1);
        req_a = 0;
        step(1);
        chk("s1_period", pwm_period, 1000);
        chk("s1_ref", pwm_ref, 500);
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("s1_en_%0d", i), pwm_en, 1);
            chk($sformatf("s1_done_%0d", i), done, (i == 12) ? 1 : 0);
            step(1);
        end
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("s1_gap_en_%0d", i), pwm_en, 0);
            chk($sformatf("s1_gap_busy_%0d", i), busy, 1);
            step(1);
        end
        chk("s1_idle", busy, 0);
        chk("s1_gap_hold_ref", pwm_ref, 500);

        // Tie from reset: A first, then alternation, 14 cycles between acks.
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        req_a = 1; req_b = 1;
        period_a = 17'd1000; dur_a = 16'd1; period_b = 17'd600; dur_b = 16'd1;
        expect_grant("rr0", 1'b0, 40, n);
        expect_grant("rr1", 1'b1, 40, n);
        chk("rr1_dist", n, 14);
        step(1);
        chk("rr1_ref", pwm_ref, 300);
        expect_grant("rr2", 1'b0, 40, n);
        chk("rr2_dist", n, 13);
        expect_grant("rr3", 1'b1, 40, n);
        chk("rr3_dist", n, 14);
        req_a = 0; req_b = 0;
        wait_idle("rr", 40);

        // Rest tone on B: silent but timed for 8 PLAY cycles.
        req_b = 1; period_b = 17'd0; dur_b = 16'd2;
        expect_grant("rest", 1'b1, 4, n);
        req_b = 0;
        step(1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("rest_en_%0d", i), pwm_en, 0);
            chk($sformatf("rest_done_%0d", i), done, (i == 8) ? 1 : 0);
            step(1);
        end
        wait_idle("rest", 20);

        // Zero duration: straight to an 8-cycle gap, no done.
        req_a = 1; period_a = 17'd1000; dur_a = 16'd0;
        expect_grant("dur0", 1'b0, 4, n);
        req_a = 0;
        step(1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("dur0_busy_%0d", i), busy, 1);
            chk($sformatf("dur0_done_%0d", i), done, 0);
            chk($sformatf("dur0_en_%0d", i), pwm_en, 0);
            step(1);
        end
        chk("dur0_idle", busy, 0);

        // Period 1 gives zero duty word.
        req_a = 1; period_a = 17'd1; dur_a = 16'd1;
        expect_grant("p1", 1'b0, 4, n);
        req_a = 0;
        step(1);
        chk("p1_period", pwm_period, 1);
        chk("p1_ref", pwm_ref, 0);
        chk("p1_en", pwm_en, 1);
        wait_idle("p1", 20);

        // Abort 5 cycles into PLAY with B pending.
        req_a = 1; period_a = 17'd200; dur_a = 16'd3;
        expect_grant("ab", 1'b0, 4, n);
        req_a = 0; req_b = 1; period_b = 17'd600; dur_b = 16'd2;
        step(5);
        chk("ab_play_en", pwm_en, 1);
        abort = 1;
        #1;
        chk("ab_no_done", done, 0);
        step(1);
        abort = 0;
        chk("ab_idle", busy, 0);
        chk("ab_en_off", pwm_en, 0);
        chk("ab_done_off", done, 0);
        step(1);
        chk("ab_pending_ack_b", ack_b, 1);
        req_b = 0;
        wait_idle("ab", 40);

        // Async reset in the middle of an A tone; then A must win a tie.
        req_a = 1; period_a = 17'd600; dur_a = 16'd2;
        expect_grant("rst", 1'b0, 4, n);
        req_a = 0;
        step(3);
        chk("rst_play_en", pwm_en, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst_async");
        step(1);
        reset = 1'b1;
        req_a = 1; req_b = 1;
        expect_grant("rst_tie", 1'b0, 4, n);
        req_a = 0; req_b = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
